wb_macro_bridge: RTL and testbench

- Wishbone slave-side bridge sitting directly upstream of the GF180 user macros (golden, decap64, decap8, tap).
- Replaces direct fan-out of the Caravel WB MI A bus to every macro: decodes the address, forwards one transaction to exactly one macro, and returns a single registered ack/data to the wrapper.
- Adds per-transaction timeout, error data on unmapped or hung accesses, and a local status/clear register.

---
 rtl/wb_bridge_pkg.sv | 29 ++
 rtl/wb_bridge_timer.sv | 25 ++
 rtl/wb_macro_bridge.sv | 184 ++++++++++++++++++
 tb/tb_wb_macro_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bridge_pkg.sv
// rtl/wb_bridge_pkg.sv - shared states, region codes and status layout for the macro bridge
package wb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOCAL,
    ERR,
    RESP
  } state_e;

  localparam logic [1:0] RGN_SLV_LO = 2'b00;
  localparam logic [1:0] RGN_SLV_HI = 2'b01;
  localparam logic [1:0] RGN_LOCAL  = 2'b10;
  localparam logic [1:0] RGN_UNMAP  = 2'b11;

  localparam int ST_TO_LSB    = 0;
  localparam int ST_UNMAP_BIT = 4;
  localparam int ST_LAST_LSB  = 8;
  localparam int ST_CNT_LSB   = 16;
  localparam int ST_CNT_CLR   = 31;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_bridge_timer.sv
// rtl/wb_bridge_timer.sv - request timer, cleared by load, holds at terminal count
module wb_bridge_timer #(
  parameter int TIMEOUT = 255,
  parameter int W       = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = (r_cnt == W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_macro_bridge.sv
// rtl/wb_macro_bridge.sv - decodes one upstream WB access to a single macro, local status or error
module wb_macro_bridge
  import wb_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          NUM_SLV   = 4,
  parameter int          SEL_LSB   = 16,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   m_cyc_o,
  output logic [NUM_SLV-1:0]     m_stb_o,
  output logic                   m_we_o,
  output logic [3:0]             m_sel_o,
  output logic [31:0]            m_adr_o,
  output logic [31:0]            m_dat_o,
  input  logic [NUM_SLV-1:0]     m_ack_i,
  input  logic [NUM_SLV*32-1:0]  m_dat_i,
  output logic                   err_irq_o
);

  state_e      r_state;
  state_e      w_next;
  logic        w_accept;
  logic        w_to_err;
  logic        w_in_base;
  logic [1:0]  w_in_rgn;
  logic        w_req;
  logic        w_tc;
  logic [31:0] w_status;
  logic [31:0] w_resp_dat;

  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [1:0]  r_idx;
  logic        r_err_to;
  logic        r_ack_q;
  logic [31:0] r_rdat_q;
  logic        r_ack_o;
  logic [31:0] r_dat_o;

  logic [3:0]  r_to_flags;
  logic        r_unmap;
  logic [7:0]  r_last_adr;
  logic [15:0] r_err_cnt;

  assign w_in_base = (wbs_adr_i[31:20] == ADDR_BASE[31:20]);
  assign w_in_rgn  = wbs_adr_i[SEL_LSB+3:SEL_LSB+2];
  assign w_req     = (r_state == REQ);
  assign w_status  = {r_err_cnt, r_last_adr, 3'b000, r_unmap, r_to_flags};

  wb_bridge_timer #(
    .TIMEOUT (TIMEOUT),
    .W       (16)
  ) u_timer (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_load  (!w_req),
    .i_en    (w_req),
    .o_tc    (w_tc)
  );

  // Abort wins over a pending ack, which in turn wins over the timeout.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_to_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          w_accept = 1'b1;
          if (!w_in_base || w_in_rgn == RGN_UNMAP) begin
            w_next = ERR;
          end else if (w_in_rgn == RGN_LOCAL) begin
            w_next = LOCAL;
          end else begin
            w_next = REQ;
          end
        end
      end
      REQ: begin
        if (!wbs_cyc_i) begin
          w_next = IDLE;
        end else if (r_ack_q) begin
          w_next = RESP;
        end else if (w_tc) begin
          w_next   = ERR;
          w_to_err = 1'b1;
        end
      end
      LOCAL:   w_next = RESP;
      ERR:     w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_resp_dat = '0;
    case (r_state)
      REQ:     w_resp_dat = r_we ? 32'h0 : r_rdat_q;
      LOCAL:   w_resp_dat = r_we ? 32'h0 : w_status;
      ERR:     w_resp_dat = ERR_DATA;
      default: w_resp_dat = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state    <= IDLE;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_idx      <= '0;
      r_err_to   <= 1'b0;
      r_ack_q    <= 1'b0;
      r_rdat_q   <= '0;
      r_ack_o    <= 1'b0;
      r_dat_o    <= '0;
      r_to_flags <= '0;
      r_unmap    <= 1'b0;
      r_last_adr <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_adr    <= wbs_adr_i;
        r_dat    <= wbs_dat_i;
        r_we     <= wbs_we_i;
        r_sel    <= wbs_sel_i;
        r_idx    <= wbs_adr_i[SEL_LSB+1:SEL_LSB];
        r_err_to <= 1'b0;
      end else if (w_to_err) begin
        r_err_to <= 1'b1;
      end
      // Slave ack and data get one input register stage before the FSM acts on them.
      r_ack_q  <= w_req && m_ack_i[r_idx];
      r_rdat_q <= m_dat_i[{r_idx, 5'd0} +: 32];
      r_ack_o  <= (w_next == RESP);
      r_dat_o  <= (w_next == RESP) ? w_resp_dat : 32'h0;

      if (r_state == ERR) begin
        if (r_err_to) begin
          r_to_flags[r_idx] <= 1'b1;
        end else begin
          r_unmap <= 1'b1;
        end
        r_last_adr <= r_adr[SEL_LSB+7:SEL_LSB];
        r_err_cnt  <= sat_inc16(r_err_cnt);
      end else if (r_state == LOCAL && r_we) begin
        r_to_flags <= r_to_flags & ~r_dat[ST_TO_LSB+3:ST_TO_LSB];
        r_unmap    <= r_unmap & ~r_dat[ST_UNMAP_BIT];
        r_last_adr <= r_last_adr & ~r_dat[ST_LAST_LSB+7:ST_LAST_LSB];
        if (r_dat[ST_CNT_CLR]) begin
          r_err_cnt <= '0;
        end
      end
    end
  end

  assign wbs_ack_o = r_ack_o;
  assign wbs_dat_o = r_dat_o;
  assign err_irq_o = (r_state == ERR);
  assign m_cyc_o   = w_req;
  assign m_stb_o   = w_req ? (NUM_SLV'(1) << r_idx) : '0;
  assign m_we_o    = w_req & r_we;
  assign m_sel_o   = w_req ? r_sel : 4'h0;
  assign m_adr_o   = w_req ? r_adr : 32'h0;
  assign m_dat_o   = w_req ? r_dat : 32'h0;

endmodule

// File: tb/tb_wb_macro_bridge.sv
// tb/tb_wb_macro_bridge.sv - directed vectors with a windowed transaction model for wb_macro_bridge
module tb_wb_macro_bridge;

  localparam int TO = 255;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_ni = 1'b0;
  logic          wbs_stb_i = 1'b0;
  logic          wbs_cyc_i = 1'b0;
  logic          wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [31:0]   wbs_adr_i = 32'h0;
  logic [31:0]   wbs_dat_i = 32'h0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          m_cyc_o;
  logic [3:0]    m_stb_o;
  logic          m_we_o;
  logic [3:0]    m_sel_o;
  logic [31:0]   m_adr_o;
  logic [31:0]   m_dat_o;
  logic [3:0]    m_ack_i = 4'h0;
  logic [127:0]  m_dat_i = 128'h0;
  logic          err_irq_o;

  wb_macro_bridge #(
    .ADDR_BASE (32'h3000_0000),
    .NUM_SLV   (4),
    .SEL_LSB   (16),
    .TIMEOUT   (TO),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .m_cyc_o   (m_cyc_o),
    .m_stb_o   (m_stb_o),
    .m_we_o    (m_we_o),
    .m_sel_o   (m_sel_o),
    .m_adr_o   (m_adr_o),
    .m_dat_o   (m_dat_o),
    .m_ack_i   (m_ack_i),
    .m_dat_i   (m_dat_i),
    .err_irq_o (err_irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  bit mon_en   = 1'b0;

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc_n);
    end
  endtask

  // Specification-level status model
  logic [4:0]  ms_sticky = '0;
  logic [7:0]  ms_last   = '0;
  int          ms_cnt    = 0;

  function automatic logic [31:0] ms_status();
    logic [15:0] c;
    c = 16'(ms_cnt);
    return {c, ms_last, 3'b000, ms_sticky};
  endfunction

  function automatic void ms_error(input int bitn, input logic [7:0] a);
    ms_sticky[bitn] = 1'b1;
    ms_last = a;
    if (ms_cnt < 65535) ms_cnt++;
  endfunction

  // Per-transaction expectation windows, relative to the request cycle
  bit          e_act = 1'b0;
  int          e_t0, e_req_end, e_ack, e_irq;
  logic [31:0] e_dat, e_adr, e_wdat;
  logic        e_we;
  logic [3:0]  e_sel, e_stb;

  int          acks, irqs, last_lat;
  logic [31:0] last_dat;

  always @(negedge wb_clk_i) begin
    int k;
    bit in_req, ack_now;
    if (mon_en) begin
      k       = e_act ? (cyc_n - e_t0) : -1;
      in_req  = e_act && (k >= 1) && (k <= e_req_end);
      ack_now = e_act && (k == e_ack);
      chk("m_cyc", {31'h0, m_cyc_o}, {31'h0, in_req});
      chk("m_stb", {28'h0, m_stb_o}, in_req ? {28'h0, e_stb} : 32'h0);
      chk("m_we",  {31'h0, m_we_o},  {31'h0, in_req & e_we});
      chk("m_sel", {28'h0, m_sel_o}, in_req ? {28'h0, e_sel} : 32'h0);
      chk("m_adr", m_adr_o, in_req ? e_adr : 32'h0);
      chk("m_dat", m_dat_o, in_req ? e_wdat : 32'h0);
      chk("wbs_ack", {31'h0, wbs_ack_o}, {31'h0, ack_now});
      chk("wbs_dat", wbs_dat_o, ack_now ? e_dat : 32'h0);
      chk("err_irq", {31'h0, err_irq_o}, {31'h0, e_act && (k == e_irq)});
      if (wbs_ack_o === 1'b1) begin
        acks++;
        last_dat = wbs_dat_o;
        last_lat = k;
      end
      if (err_irq_o === 1'b1) irqs++;
    end
  end

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    int          d;
    logic [3:0]  mask;
    logic [31:0] sdat;
    int          abort_k;
    int          rst_k;
    int          x_acks;
    int          x_lat;
    int          x_irqs;
    logic [31:0] x_dat;
  } vec_t;

  vec_t vecs[15];

  task automatic run(input int n, input vec_t v);
    logic [1:0] rgn, idx;
    bit         base_ok;
    int         lend;
    @(posedge wb_clk_i);
    #1;
    rgn     = v.adr[19:18];
    idx     = v.adr[17:16];
    base_ok = (v.adr[31:20] == 12'h300);
    e_t0 = cyc_n; e_req_end = 0; e_ack = -1; e_irq = -1; e_dat = 32'h0;
    e_adr = v.adr; e_wdat = v.wdat; e_we = v.we; e_sel = v.sel; e_stb = 4'b0001 << idx;
    if (!base_ok || rgn == 2'b11) begin
      e_irq = 1; e_ack = 2; e_dat = 32'hDEAD_BEEF; lend = 3;
      ms_error(4, v.adr[23:16]);
    end else if (rgn == 2'b10) begin
      e_ack = 2; lend = 3;
      e_dat = v.we ? 32'h0 : ms_status();
      if (v.we) begin
        ms_sticky = ms_sticky & ~v.wdat[4:0];
        ms_last   = ms_last & ~v.wdat[15:8];
        if (v.wdat[31]) ms_cnt = 0;
      end
    end else if (v.abort_k > 0) begin
      e_req_end = v.abort_k; lend = v.abort_k + 2;
    end else if (v.rst_k > 0) begin
      e_req_end = v.rst_k; lend = v.rst_k + 3;
      ms_sticky = '0; ms_last = '0; ms_cnt = 0;
    end else if (v.d > 0 && v.mask[idx]) begin
      e_req_end = v.d + 1; e_ack = v.d + 2; lend = e_ack + 1;
      e_dat = v.we ? 32'h0 : v.sdat;
    end else begin
      e_req_end = TO; e_irq = TO + 1; e_ack = TO + 2; lend = e_ack + 1;
      e_dat = 32'hDEAD_BEEF;
      ms_error(int'(idx), v.adr[23:16]);
    end
    acks = 0; irqs = 0; last_lat = -1; last_dat = 32'h0;
    e_act = 1'b1;
    for (int s = 0; s < 4; s++) begin
      m_dat_i[s*32 +: 32] = (s == int'(idx)) ? v.sdat : (32'hBAD0_0000 | 32'(s));
    end
    wbs_adr_i = v.adr; wbs_dat_i = v.wdat; wbs_we_i = v.we; wbs_sel_i = v.sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; m_ack_i = 4'h0;
    for (int k = 1; k <= lend; k++) begin
      @(posedge wb_clk_i);
      #1;
      m_ack_i = (k == v.d) ? v.mask : 4'h0;
      if ((e_ack > 0 && k == e_ack + 1) || (v.abort_k > 0 && k == v.abort_k) ||
          (v.rst_k > 0 && k == v.rst_k)) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
      if (v.rst_k > 0 && k == v.rst_k)     wb_rst_ni = 1'b0;
      if (v.rst_k > 0 && k == v.rst_k + 1) wb_rst_ni = 1'b1;
    end
    @(posedge wb_clk_i);
    #1;
    e_act = 1'b0;
    m_ack_i = 4'h0;
    chk($sformatf("v%0d_acks", n), 32'(acks), 32'(v.x_acks));
    chk($sformatf("v%0d_irqs", n), 32'(irqs), 32'(v.x_irqs));
    if (v.x_acks > 0) begin
      chk($sformatf("v%0d_lat", n), 32'(last_lat), 32'(v.x_lat));
      chk($sformatf("v%0d_dat", n), last_dat, v.x_dat);
    end
  endtask

  initial begin
    // adr, wdat, we, sel, d, mask, sdat, abort, rst, acks, lat, irqs, dat
    vecs[0]  = '{32'h3001_0004, 32'h0,         1'b0, 4'hF, 3, 4'b0010, 32'h1234_5678, 0, 0, 1, 5,   0, 32'h1234_5678};
    vecs[1]  = '{32'h3003_0000, 32'hA5A5_A5A5, 1'b1, 4'hF, 2, 4'b1000, 32'h5555_0003, 0, 0, 1, 4,   0, 32'h0};
    vecs[2]  = '{32'h3002_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h7777_0002, 0, 0, 1, 257, 1, 32'hDEAD_BEEF};
    vecs[3]  = '{32'h3008_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   0, 32'h0001_0204};
    vecs[4]  = '{32'h4000_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   1, 32'hDEAD_BEEF};
    vecs[5]  = '{32'h3008_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   0, 32'h0002_0014};
    vecs[6]  = '{32'h3008_0000, 32'h8000_0014, 1'b1, 4'hF, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   0, 32'h0};
    vecs[7]  = '{32'h3008_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   0, 32'h0};
    vecs[8]  = '{32'h3000_0010, 32'h0,         1'b0, 4'hF, 2, 4'b0011, 32'hCAFE_0000, 0, 0, 1, 4,   0, 32'hCAFE_0000};
    vecs[9]  = '{32'h300C_0000, 32'h0,         1'b0, 4'h1, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   1, 32'hDEAD_BEEF};
    vecs[10] = '{32'h3002_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         2, 0, 0, 0,   0, 32'h0};
    vecs[11] = '{32'h3008_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   0, 32'h0001_0C10};
    vecs[12] = '{32'h3001_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         0, 2, 0, 0,   0, 32'h0};
    vecs[13] = '{32'h3008_0000, 32'h0,         1'b0, 4'hF, 0, 4'b0000, 32'h0,         0, 0, 1, 2,   0, 32'h0};
    vecs[14] = '{32'h3000_0008, 32'h0F0F_1234, 1'b1, 4'h3, 1, 4'b0001, 32'h9999_0000, 0, 0, 1, 3,   0, 32'h0};

    wb_rst_ni = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_m_cyc",   {31'h0, m_cyc_o},   32'h0);
    chk("rst_m_stb",   {28'h0, m_stb_o},   32'h0);
    chk("rst_m_we",    {31'h0, m_we_o},    32'h0);
    chk("rst_m_adr",   m_adr_o,            32'h0);
    chk("rst_m_dat",   m_dat_o,            32'h0);
    chk("rst_wbs_ack", {31'h0, wbs_ack_o}, 32'h0);
    chk("rst_wbs_dat", wbs_dat_o,          32'h0);
    chk("rst_irq",     {31'h0, err_irq_o}, 32'h0);
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run(i, vecs[i]);
    end

    repeat (2) @(posedge wb_clk_i);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
